tick_gen_ctrl: RTL and testbench

TICK_GEN_CTRL -- requirements
Module: tick_gen_ctrl

---
 rtl/tick_gen_ctrl.sv | 119 +++++++++++
 tb/tb_tick_gen_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_ctrl.sv
// Programmable tick generator: emits a one-cycle clock-enable pulse every
// div_reg+1 cycles, either continuously (periodic) or for a fixed burst (one-shot).
module tick_gen_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [7:0]       cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [7:0]       tick_cnt
);

  // Handshake: a configuration transfer happens on a rising edge where
  // cfg_valid && cfg_ready; cfg_ready is high only in IDLE and depends on state alone.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       tick_cnt_q, tick_cnt_d;

  logic             cfg_fire;
  logic             eff_mode;
  logic [7:0]       eff_count;
  logic             at_period;
  logic [7:0]       tick_cnt_inc;

  assign cfg_fire     = cfg_valid && (state_q == IDLE);
  // A start on the same edge as a handshake must use the freshly offered values.
  assign eff_mode     = cfg_fire ? cfg_mode  : mode_q;
  assign eff_count    = cfg_fire ? cfg_count : count_q;
  assign at_period    = (state_q == RUN) && (cnt_q == div_q);
  assign tick_cnt_inc = tick_cnt_q + 8'd1;

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign tick      = at_period && !stop;
  assign tick_cnt  = tick_cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    mode_d     = mode_q;
    count_d    = count_q;
    tick_cnt_d = tick_cnt_q;

    if (cfg_fire) begin
      div_d   = cfg_div;
      mode_d  = cfg_mode;
      count_d = cfg_count;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d      = '0;
          tick_cnt_d = 8'd0;
          if (eff_mode && (eff_count == 8'd0)) state_d = DONE;
          else                                 state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (at_period) begin
          cnt_d      = '0;
          tick_cnt_d = tick_cnt_inc;
          if (mode_q && (tick_cnt_inc == count_q)) state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= CNT_W'(DEFAULT_DIV);
      mode_q     <= 1'b0;
      count_q    <= 8'd0;
      tick_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: tb/tb_tick_gen_ctrl.sv
// Directed bench for tick_gen_ctrl: reset values, periodic/one-shot timing,
// stop priority, ignored config/start while running, asynchronous reset.
module tb_tick_gen_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [7:0]  cfg_count;
  logic        start;
  logic        stop;
  logic        tick;
  logic        busy;
  logic        done;
  logic [7:0]  tick_cnt;

  int checks   = 0;
  int failures = 0;

  tick_gen_ctrl #(.CNT_W(16), .DEFAULT_DIV(31)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_count (cfg_count),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .tick_cnt  (tick_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [15:0] d, input logic m, input logic [7:0] c, input logic s);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_mode  = m;
    cfg_count = c;
    start     = s;
    step();
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Counts cycles from the current one (=1) until tick is seen, bounded.
  task automatic measure_gap(input int max_cyc, output int n);
    n = 1;
    while (tick !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] exp_tc;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_mode = 1'b0;
    cfg_count = '0; start = 1'b0; stop = 1'b0;
    #22;
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_tick_cnt", 32'(tick_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Default divide: first tick 32 cycles after start, then every 32
    do_start();
    check_eq("def_busy", 32'(busy), 32'd1);
    check_eq("def_cfg_ready", 32'(cfg_ready), 32'd0);
    measure_gap(100, n);
    check_eq("def_first_tick", 32'(n), 32'd32);
    step();
    check_eq("def_tick_cnt1", 32'(tick_cnt), 32'd1);
    measure_gap(100, n);
    check_eq("def_second_gap", 32'(n), 32'd32);
    step();
    do_stop();
    check_eq("def_stop_busy", 32'(busy), 32'd0);
    check_eq("def_stop_tick_cnt", 32'(tick_cnt), 32'd2);

    // Periodic div=3 with config and start on the same edge; tick_cnt wraps
    do_cfg(16'd3, 1'b0, 8'd0, 1'b1);
    exp_tc = 8'd0;
    for (int c = 1; c <= 1100; c++) begin
      check_eq("p3_tick", 32'(tick), 32'((c % 4) == 0));
      check_eq("p3_tick_cnt", 32'(tick_cnt), 32'(exp_tc));
      if ((c % 4) == 0) exp_tc = exp_tc + 8'd1;
      step();
    end
    check_eq("p3_wrapped_cnt", 32'(tick_cnt), 32'd19);
    do_stop();

    // One-shot div=2 count=5
    do_cfg(16'd2, 1'b1, 8'd5, 1'b0);
    do_start();
    for (int c = 1; c <= 15; c++) begin
      check_eq("os_tick", 32'(tick), 32'((c % 3) == 0));
      check_eq("os_done_low", 32'(done), 32'd0);
      check_eq("os_busy", 32'(busy), 32'd1);
      step();
    end
    check_eq("os_done", 32'(done), 32'd1);
    check_eq("os_tick_cnt", 32'(tick_cnt), 32'd5);
    check_eq("os_done_ready", 32'(cfg_ready), 32'd0);
    check_eq("os_done_busy", 32'(busy), 32'd0);
    step();
    check_eq("os_done_clear", 32'(done), 32'd0);
    check_eq("os_ready_after", 32'(cfg_ready), 32'd1);

    // One-shot count=0: straight to DONE, no tick
    do_cfg(16'd2, 1'b1, 8'd0, 1'b1);
    check_eq("os0_done", 32'(done), 32'd1);
    check_eq("os0_tick", 32'(tick), 32'd0);
    check_eq("os0_busy", 32'(busy), 32'd0);
    check_eq("os0_tick_cnt", 32'(tick_cnt), 32'd0);
    step();
    check_eq("os0_done_clear", 32'(done), 32'd0);
    check_eq("os0_ready", 32'(cfg_ready), 32'd1);

    // div=0 periodic: tick every RUN cycle
    do_cfg(16'd0, 1'b0, 8'd0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      check_eq("d0_tick", 32'(tick), 32'd1);
      check_eq("d0_tick_cnt", 32'(tick_cnt), 32'(c - 1));
      step();
    end
    do_stop();

    // div=7: config and start ignored in RUN, stop in a tick cycle
    do_cfg(16'd7, 1'b0, 8'd0, 1'b1);
    cfg_valid = 1'b1; cfg_div = 16'd2; cfg_mode = 1'b1; cfg_count = 8'd1;
    check_eq("run_cfg_ready", 32'(cfg_ready), 32'd0);
    step();
    step();
    cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    measure_gap(50, n);
    check_eq("d7_first_tick", 32'(n), 32'd5);
    step();
    measure_gap(50, n);
    check_eq("d7_gap", 32'(n), 32'd8);
    check_eq("d7_tick_cnt", 32'(tick_cnt), 32'd1);
    stop = 1'b1;
    #1;
    check_eq("stop_kills_tick", 32'(tick), 32'd0);
    step();
    stop = 1'b0;
    check_eq("stop_busy", 32'(busy), 32'd0);
    check_eq("stop_ready", 32'(cfg_ready), 32'd1);
    check_eq("stop_tick_cnt", 32'(tick_cnt), 32'd1);
    do_stop();
    check_eq("idle_stop_ready", 32'(cfg_ready), 32'd1);
    do_start();
    measure_gap(50, n);
    check_eq("regs_kept_div", 32'(n), 32'd8);
    step();
    check_eq("regs_kept_mode", 32'(busy), 32'd1);
    do_stop();

    // Asynchronous reset mid-burst
    do_cfg(16'd2, 1'b1, 8'd5, 1'b1);
    step();
    step();
    check_eq("pre_rst_tick", 32'(tick), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tick", 32'(tick), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_ready", 32'(cfg_ready), 32'd1);
    check_eq("arst_tick_cnt", 32'(tick_cnt), 32'd0);
    step();
    #2;
    rst_n = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      check_eq("arst_no_done", 32'(done), 32'd0);
      step();
    end
    do_start();
    measure_gap(100, n);
    check_eq("arst_div_default", 32'(n), 32'd32);
    step();
    check_eq("arst_mode_default", 32'(busy), 32'd1);
    do_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
